crc_stream_engine: RTL and testbench

//  Parametrised streaming CRC engine; successor to crc16_parallel. Generalises width, polynomial, init,

---
 rtl/crc_pkg.sv | 41 ++++
 rtl/crc_stream_engine_step.sv | 47 ++++
 rtl/crc_stream_engine.sv | 146 ++++++++++++++
 tb/tb_crc_stream_engine.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crc_pkg
// Description : Shared constants, FSM state type and bit-reflection helpers
//               for the streaming CRC engine.
// Revision    : 1.0 - initial release
// ============================================================================
package crc_pkg;

    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [15:0] CRC16_IBM_POLY   = 16'h8005;
    localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } crc_state_e;

    function automatic logic [7:0] reflect8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    // Reflects the low n bits of v; bits at and above n come back as zero.
    function automatic logic [31:0] reflectN(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) begin
                r[n-1-i] = v[i];
            end
        end
        return r;
    endfunction

endpackage : crc_pkg
`default_nettype wire

// File: rtl/crc_stream_engine_step.sv
`default_nettype none
// ============================================================================
// Module      : crc_step
// Description : Combinational CRC update over one DATA_W-bit beat, fully
//               unrolled, MSB first (input bytes optionally reflected).
// Revision    : 1.0 - initial release
// ============================================================================
module crc_step
    import crc_pkg::*;
#(
    parameter int               DATA_W = 16,
    parameter int               CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC16_CCITT_POLY),
    parameter bit               REFIN  = 1'b0
)
(
    input  logic [CRC_W-1:0]  i_crc,
    input  logic [DATA_W-1:0] i_data,
    output logic [CRC_W-1:0]  o_crc
);

    logic [DATA_W-1:0] w_data;
    logic [CRC_W-1:0]  w_acc;
    logic              w_fb;

    generate
        if (REFIN) begin : g_refin
            for (genvar b = 0; b < DATA_W / 8; b++) begin : g_byte
                assign w_data[8*b +: 8] = reflect8(i_data[8*b +: 8]);
            end
        end else begin : g_norefin
            assign w_data = i_data;
        end
    endgenerate

    always_comb begin
        w_acc = i_crc;
        w_fb  = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            w_fb  = w_acc[CRC_W-1] ^ w_data[i];
            w_acc = {w_acc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
        end
        o_crc = w_acc;
    end

endmodule : crc_step
`default_nettype wire

// File: rtl/crc_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : crc_stream_engine
// Description : Framed streaming CRC engine with valid/ready on both sides,
//               one beat per clock and a held per-frame result.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int               DATA_W = 16,
    parameter int               CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC16_CCITT_POLY),
    parameter logic [CRC_W-1:0] INIT   = {CRC_W{1'b1}},
    parameter bit               REFIN  = 1'b0,
    parameter bit               REFOUT = 1'b0,
    parameter logic [CRC_W-1:0] XOROUT = '0
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_first,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CRC_W-1:0]  m_crc,
    output logic [15:0]       m_beats,
    output logic [CRC_W-1:0]  crc_run,
    output logic              frame_abort
);

    crc_state_e        r_state;
    crc_state_e        w_next;
    logic [CRC_W-1:0]  r_crc;
    logic [15:0]       r_cnt;
    logic              r_mvalid;
    logic [CRC_W-1:0]  r_mcrc;
    logic [15:0]       r_mbeats;
    logic              r_abort;

    logic              w_accept;
    logic              w_from_init;
    logic              w_restart;
    logic              w_result_take;
    logic [CRC_W-1:0]  w_base;
    logic [CRC_W-1:0]  w_step;
    logic [CRC_W-1:0]  w_out;
    logic [CRC_W-1:0]  w_final;
    logic [15:0]       w_cnt_next;

    assign s_ready       = (r_state != RESULT);
    assign w_accept      = s_valid && s_ready && !clear;
    assign w_from_init   = (r_state == IDLE) || s_first;
    assign w_restart     = (r_state == ACCUM) && s_first;
    assign w_result_take = (r_state == RESULT) && m_ready;
    assign w_base        = w_from_init ? INIT : r_crc;
    assign w_cnt_next    = w_from_init          ? 16'd1 :
                           (r_cnt == 16'hFFFF)  ? r_cnt : r_cnt + 16'd1;

    crc_step #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W),
        .POLY   (POLY),
        .REFIN  (REFIN)
    ) u_step (
        .i_crc  (w_base),
        .i_data (s_data),
        .o_crc  (w_step)
    );

    assign w_out   = REFOUT ? CRC_W'(reflectN(32'(w_step), CRC_W)) : w_step;
    assign w_final = w_out ^ XOROUT;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, ACCUM: begin
                if (w_accept) begin
                    w_next = s_last ? RESULT : ACCUM;
                end
            end
            RESULT: begin
                if (m_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (clear) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_crc    <= INIT;
            r_cnt    <= '0;
            r_mvalid <= 1'b0;
            r_mcrc   <= '0;
            r_mbeats <= '0;
            r_abort  <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            if (clear) begin
                // Any beat presented alongside clear is dropped.
                r_crc    <= INIT;
                r_cnt    <= '0;
                r_mvalid <= 1'b0;
                r_abort  <= (r_state != IDLE);
            end else if (w_accept) begin
                r_crc   <= w_step;
                r_cnt   <= w_cnt_next;
                r_abort <= w_restart;
                if (s_last) begin
                    r_mvalid <= 1'b1;
                    r_mcrc   <= w_final;
                    r_mbeats <= w_cnt_next;
                end
            end else if (w_result_take) begin
                r_mvalid <= 1'b0;
                r_crc    <= INIT;
                r_cnt    <= '0;
            end
        end
    end

    assign m_valid     = r_mvalid;
    assign m_crc       = r_mcrc;
    assign m_beats     = r_mbeats;
    assign crc_run     = r_crc;
    assign frame_abort = r_abort;

endmodule : crc_stream_engine
`default_nettype wire

// File: tb/tb_crc_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_stream_engine
// Description : Randomized self-checking bench; three byte-wide engine
//               configurations share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_stream_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_first;
    logic        s_last;
    logic        m_ready;

    logic        rdy_a, rdy_b, rdy_c;
    logic        mv_a, mv_b, mv_c;
    logic [15:0] crc_a, crc_b;
    logic [31:0] crc_c;
    logic [15:0] bt_a, bt_b, bt_c;
    logic [15:0] run_a, run_b;
    logic [31:0] run_c;
    logic        ab_a, ab_b, ab_c;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    crc_stream_engine #(
        .DATA_W(8), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF),
        .REFIN(1'b0), .REFOUT(1'b0), .XOROUT(16'h0000)
    ) u_ccitt (
        .clk(clk), .reset(reset), .clear(clear), .s_valid(s_valid), .s_ready(rdy_a),
        .s_data(s_data), .s_first(s_first), .s_last(s_last), .m_valid(mv_a),
        .m_ready(m_ready), .m_crc(crc_a), .m_beats(bt_a), .crc_run(run_a),
        .frame_abort(ab_a)
    );

    crc_stream_engine #(
        .DATA_W(8), .CRC_W(16), .POLY(16'h8005), .INIT(16'h0000),
        .REFIN(1'b1), .REFOUT(1'b1), .XOROUT(16'h0000)
    ) u_arc (
        .clk(clk), .reset(reset), .clear(clear), .s_valid(s_valid), .s_ready(rdy_b),
        .s_data(s_data), .s_first(s_first), .s_last(s_last), .m_valid(mv_b),
        .m_ready(m_ready), .m_crc(crc_b), .m_beats(bt_b), .crc_run(run_b),
        .frame_abort(ab_b)
    );

    crc_stream_engine #(
        .DATA_W(8), .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
        .REFIN(1'b1), .REFOUT(1'b1), .XOROUT(32'hFFFFFFFF)
    ) u_crc32 (
        .clk(clk), .reset(reset), .clear(clear), .s_valid(s_valid), .s_ready(rdy_c),
        .s_data(s_data), .s_first(s_first), .s_last(s_last), .m_valid(mv_c),
        .m_ready(m_ready), .m_crc(crc_c), .m_beats(bt_c), .crc_run(run_c),
        .frame_abort(ab_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rev(input logic [31:0] v, input int w);
        logic [31:0] r = '0;
        for (int i = 0; i < w; i++) r[w-1-i] = v[i];
        return r;
    endfunction

    // Textbook byte-wise CRC: left-shifting for normal form, right-shifting
    // with a mirrored polynomial for the reflected form.
    function automatic logic [31:0] model_crc(input int w, input logic [31:0] poly,
                                              input logic [31:0] init, input bit refl,
                                              input logic [31:0] xorout, input logic [7:0] msg[$]);
        logic [31:0] mask = (w == 32) ? 32'hFFFFFFFF : ((32'h1 << w) - 32'h1);
        logic [31:0] c;
        logic [31:0] rp;
        if (!refl) begin
            c = init;
            foreach (msg[k]) begin
                c = c ^ (32'(msg[k]) << (w - 8));
                for (int b = 0; b < 8; b++)
                    c = c[w-1] ? (((c << 1) ^ poly) & mask) : ((c << 1) & mask);
            end
        end else begin
            rp = rev(poly, w);
            c  = rev(init, w);
            foreach (msg[k]) begin
                c = c ^ 32'(msg[k]);
                for (int b = 0; b < 8; b++)
                    c = c[0] ? ((c >> 1) ^ rp) : (c >> 1);
            end
        end
        return (c ^ xorout) & mask;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input bit f, input bit l);
        s_valid = 1'b1;
        s_data  = d;
        s_first = f;
        s_last  = l;
        check_eq("s_ready_beat", 32'(rdy_a), 32'd1);
        tick();
    endtask

    logic [15:0] last_a, last_b;
    logic [31:0] last_c;

    task automatic run_frame(input logic [7:0] msg[$], input int restart, input bit implicit,
                             input int gap_max, input int hold);
        logic [7:0]  q[$];
        logic [31:0] e_a, e_b, e_c, e_bt;
        int          g;
        q = {};
        m_ready = 1'b0;
        for (int i = 0; i < msg.size(); i++) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                s_first = 1'($urandom);
                s_last  = 1'($urandom);
                tick();
            end
            if (i == restart) q = {};
            q.push_back(msg[i]);
            send_beat(msg[i], (i == 0 && !implicit) || (i == restart), i == msg.size() - 1);
            check_eq("frame_abort", 32'(ab_a), (i == restart) ? 32'd1 : 32'd0);
        end
        s_valid = 1'b0;
        e_a  = model_crc(16, 32'h1021, 32'hFFFF, 1'b0, 32'h0, q);
        e_b  = model_crc(16, 32'h8005, 32'h0000, 1'b1, 32'h0, q);
        e_c  = model_crc(32, 32'h04C11DB7, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, q);
        e_bt = (q.size() > 65535) ? 32'd65535 : 32'(q.size());
        check_eq("m_valid", 32'(mv_a), 32'd1);
        check_eq("m_crc_ccitt", 32'(crc_a), e_a);
        check_eq("m_crc_arc", 32'(crc_b), e_b);
        check_eq("m_crc_crc32", crc_c, e_c);
        check_eq("m_beats", 32'(bt_a), e_bt);
        check_eq("s_ready_result", 32'(rdy_a), 32'd0);
        last_a = crc_a;
        last_b = crc_b;
        last_c = crc_c;
        for (int k = 0; k < hold; k++) begin
            s_valid = 1'($urandom);
            s_data  = 8'($urandom);
            s_first = 1'($urandom);
            s_last  = 1'($urandom);
            tick();
            check_eq("hold_m_valid", 32'(mv_a), 32'd1);
            check_eq("hold_m_crc", 32'(crc_a), e_a);
            check_eq("hold_m_beats", 32'(bt_a), e_bt);
            check_eq("hold_s_ready", 32'(rdy_a), 32'd0);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        s_valid = 1'b0;
        check_eq("post_m_valid", 32'(mv_a), 32'd0);
        check_eq("post_s_ready", 32'(rdy_a), 32'd1);
        check_eq("post_run_ccitt", 32'(run_a), 32'hFFFF);
        check_eq("post_run_crc32", run_c, 32'hFFFFFFFF);
    endtask

    logic [7:0] digits[$];
    logic [7:0] msg[$];

    initial begin
        digits = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        reset = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        s_first = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        repeat (3) tick();
        check_eq("rst_m_valid", 32'(mv_a), 32'd0);
        check_eq("rst_m_crc", 32'(crc_a), 32'd0);
        check_eq("rst_m_beats", 32'(bt_a), 32'd0);
        check_eq("rst_abort", 32'(ab_a), 32'd0);
        check_eq("rst_run_ccitt", 32'(run_a), 32'hFFFF);
        check_eq("rst_run_arc", 32'(run_b), 32'h0000);
        check_eq("rst_run_crc32", run_c, 32'hFFFFFFFF);
        reset = 1'b1;
        tick();
        check_eq("rel_s_ready", 32'(rdy_a), 32'd1);

        // Known-answer frames, then a held result.
        run_frame(digits, -1, 1'b0, 0, 0);
        check_eq("kat_ccitt", 32'(last_a), 32'h29B1);
        check_eq("kat_arc", 32'(last_b), 32'hBB3D);
        check_eq("kat_crc32", last_c, 32'hCBF43926);
        check_eq("kat_beats_wait", 32'(bt_a), 32'd9);
        run_frame(digits, -1, 1'b0, 0, 5);
        check_eq("hold_kat", 32'(last_a), 32'h29B1);

        // Restart on '5', single-beat frame, implicit start.
        run_frame(digits, 4, 1'b0, 0, 1);
        msg = '{8'hA5};
        run_frame(msg, -1, 1'b0, 0, 0);
        run_frame(digits, -1, 1'b1, 2, 2);
        check_eq("implicit_kat", 32'(last_a), 32'h29B1);

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 4; i++) send_beat(digits[i], i == 0, 1'b0);
        s_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_eq("midrst_m_valid", 32'(mv_a), 32'd0);
        check_eq("midrst_run", 32'(run_a), 32'hFFFF);
        check_eq("midrst_s_ready", 32'(rdy_a), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_eq("midrst_no_valid", 32'(mv_a), 32'd0);
        run_frame(digits, -1, 1'b0, 0, 0);
        check_eq("midrst_kat", 32'(last_a), 32'h29B1);

        // Clear mid-frame with a would-be last beat presented.
        for (int i = 0; i < 4; i++) send_beat(digits[i], i == 0, 1'b0);
        clear = 1'b1; s_valid = 1'b1; s_data = 8'h39; s_first = 1'b0; s_last = 1'b1;
        tick();
        clear = 1'b0; s_valid = 1'b0;
        check_eq("clr_abort", 32'(ab_a), 32'd1);
        check_eq("clr_m_valid", 32'(mv_a), 32'd0);
        check_eq("clr_run", 32'(run_a), 32'hFFFF);
        tick();
        check_eq("clr_abort_end", 32'(ab_a), 32'd0);
        check_eq("clr_no_valid", 32'(mv_a), 32'd0);
        run_frame(digits, -1, 1'b0, 0, 0);
        check_eq("clr_kat", 32'(last_a), 32'h29B1);

        // Clear while holding a result, then clear while idle.
        send_beat(8'h5A, 1'b1, 1'b1);
        s_valid = 1'b0;
        check_eq("res_m_valid", 32'(mv_a), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clr_res_m_valid", 32'(mv_a), 32'd0);
        check_eq("clr_res_abort", 32'(ab_a), 32'd1);
        check_eq("clr_res_s_ready", 32'(rdy_a), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clr_idle_abort", 32'(ab_a), 32'd0);

        // Randomized frames.
        for (int f = 0; f < 30; f++) begin
            int len;
            int rs;
            len = int'($urandom_range(12, 1));
            msg = {};
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            rs = (len > 1 && $urandom_range(3, 0) == 0) ? int'($urandom_range(len - 1, 1)) : -1;
            run_frame(msg, rs, $urandom_range(3, 0) == 0, 2, int'($urandom_range(3, 0)));
        end

        // Beat-counter saturation.
        msg = {};
        for (int i = 0; i < 65537; i++) msg.push_back(8'($urandom));
        run_frame(msg, -1, 1'b0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_crc_stream_engine
`default_nettype wire
